// File: rtl/blk_ctrl_multi_monitor_pkg.sv
// Shared definitions for the ap_ctrl block-control monitor:
// error bit positions, finish FSM states and the latency statistics record.
package blk_ctrl_mon_pkg;

  localparam int ERR_ORPHAN_DONE  = 0;
  localparam int ERR_OVERFLOW     = 1;
  localparam int ERR_IDLE_BUSY    = 2;
  localparam int ERR_CNT_MISMATCH = 3;
  localparam int ERR_W            = 4;

  localparam int STAT_LAT_W = 24;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REPORT = 2'd1,
    DONE   = 2'd2
  } fsm_e;

  typedef struct packed {
    logic [STAT_LAT_W-1:0] last;
    logic [STAT_LAT_W-1:0] min;
    logic [STAT_LAT_W-1:0] max;
  } lat_stats_t;

endpackage

// File: rtl/blk_ctrl_multi_monitor_if.sv
// Bundle of per-channel ap_ctrl_hs / ap_ctrl_chain handshake lines.
// The kernel side drives (master); the monitor only observes (slave).
interface blk_ctrl_multi_monitor_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_idle;
  logic [NUM_CH-1:0] ap_continue;

  modport master (output ap_start, ap_ready, ap_done, ap_idle, ap_continue);
  modport slave  (input  ap_start, ap_ready, ap_done, ap_idle, ap_continue);
endinterface

// File: rtl/blk_ctrl_multi_monitor_chan_mon.sv
// One monitored ap_ctrl channel: in-flight timestamp FIFO, saturating
// accept/completion counters, latency statistics and sticky error flags.
module blk_ctrl_chan_mon
  import blk_ctrl_mon_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int LAT_W     = 24,
  parameter int DEPTH     = 8,
  parameter int CHAIN     = 1,
  parameter int CHECK_REF = 1,
  parameter int OCW       = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             freeze_i,
  input  logic             report_i,
  input  logic             start_i,
  input  logic             ready_i,
  input  logic             done_i,
  input  logic             idle_i,
  input  logic             continue_i,
  input  logic [LAT_W-1:0] now_i,
  input  logic [CNT_W-1:0] ref_cnt_i,
  output logic [CNT_W-1:0] trans_cnt_o,
  output logic [CNT_W-1:0] done_cnt_o,
  output logic [OCW-1:0]   outstanding_o,
  output logic [LAT_W-1:0] lat_last_o,
  output logic [LAT_W-1:0] lat_min_o,
  output logic [LAT_W-1:0] lat_max_o,
  output logic [ERR_W-1:0] err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [LAT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [OCW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] trans_q, trans_d, done_q, done_d;
  logic [LAT_W-1:0] last_q, last_d, min_q, min_d, max_q, max_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             acc_s, cpl_s, empty_s, full_s, push_s, lat_upd_s;
  logic [LAT_W-1:0] lat_s;

  assign acc_s   = start_i & ready_i & ~freeze_i;
  assign cpl_s   = ((CHAIN != 0) ? (done_i & continue_i) : done_i) & ~freeze_i;
  assign empty_s = (cnt_q == {OCW{1'b0}});
  assign full_s  = (cnt_q == OCW'(DEPTH));

  // FIFO bookkeeping, counters and error flags for this cycle's events
  always_comb begin
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    push_s    = 1'b0;
    lat_upd_s = 1'b0;
    lat_s     = {LAT_W{1'b0}};

    if (acc_s && (trans_q != CNT_MAX)) trans_d = trans_q + CNT_W'(1);
    else                               trans_d = trans_q;
    if (cpl_s && (done_q != CNT_MAX))  done_d = done_q + CNT_W'(1);
    else                               done_d = done_q;

    // Start and done together on an idle channel is a combinational block.
    if (acc_s && cpl_s && empty_s) begin
      lat_upd_s = 1'b1;
    end else begin
      if (cpl_s && empty_s) begin
        err_d[ERR_ORPHAN_DONE] = 1'b1;
      end else if (cpl_s) begin
        lat_s     = now_i - mem_q[rd_q];
        lat_upd_s = 1'b1;
        rd_d      = rd_q + AW'(1);
        cnt_d     = cnt_q - OCW'(1);
      end else begin
        rd_d = rd_q;
      end
      if (acc_s && full_s && !cpl_s) begin
        err_d[ERR_OVERFLOW] = 1'b1;
      end else if (acc_s) begin
        push_s = 1'b1;
        wr_d   = wr_q + AW'(1);
        cnt_d  = cnt_d + OCW'(1);
      end else begin
        wr_d = wr_q;
      end
    end

    if (idle_i && !empty_s && !cpl_s && !freeze_i) err_d[ERR_IDLE_BUSY] = 1'b1;
    else                                           err_d[ERR_IDLE_BUSY] = err_q[ERR_IDLE_BUSY];

    if (report_i && (CHECK_REF != 0) && (trans_q != ref_cnt_i)) err_d[ERR_CNT_MISMATCH] = 1'b1;
    else                                                         err_d[ERR_CNT_MISMATCH] = err_q[ERR_CNT_MISMATCH];
  end

  // Latency statistics update
  always_comb begin
    if (lat_upd_s) begin
      last_d = lat_s;
      min_d  = (lat_s < min_q) ? lat_s : min_q;
      max_d  = (lat_s > max_q) ? lat_s : max_q;
    end else begin
      last_d = last_q;
      min_d  = min_q;
      max_d  = max_q;
    end
  end

  // Channel state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q    <= {AW{1'b0}};
      wr_q    <= {AW{1'b0}};
      cnt_q   <= {OCW{1'b0}};
      trans_q <= {CNT_W{1'b0}};
      done_q  <= {CNT_W{1'b0}};
      last_q  <= {LAT_W{1'b0}};
      min_q   <= {LAT_W{1'b1}};
      max_q   <= {LAT_W{1'b0}};
      err_q   <= {ERR_W{1'b0}};
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      trans_q <= trans_d;
      done_q  <= done_d;
      last_q  <= last_d;
      min_q   <= min_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

  // Timestamp storage; stale entries are harmless once the pointers are reset
  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_q] <= now_i;
  end

  assign trans_cnt_o   = trans_q;
  assign done_cnt_o    = done_q;
  assign outstanding_o = cnt_q;
  assign lat_last_o    = last_q;
  assign lat_min_o     = min_q;
  assign lat_max_o     = max_q;
  assign err_o         = err_q;

endmodule

// File: rtl/blk_ctrl_multi_monitor.sv
// Multi-channel ap_ctrl trace monitor: shared cycle counter, finish/report
// FSM, and one channel monitor per handshake with flattened result buses.
module blk_ctrl_multi_monitor
  import blk_ctrl_mon_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int LAT_W     = 24,
  parameter int DEPTH     = 8,
  parameter int CHAIN     = 1,
  parameter int CHECK_REF = 1,
  localparam int OCW      = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  blk_ctrl_multi_monitor_if.slave ctrl_if,
  input  logic                    finish_i,
  input  logic [NUM_CH*CNT_W-1:0] ref_trans_cnt_i,
  output logic [NUM_CH*CNT_W-1:0] trans_cnt_o,
  output logic [NUM_CH*CNT_W-1:0] done_cnt_o,
  output logic [NUM_CH*OCW-1:0]   outstanding_o,
  output logic [NUM_CH*LAT_W-1:0] lat_last_o,
  output logic [NUM_CH*LAT_W-1:0] lat_min_o,
  output logic [NUM_CH*LAT_W-1:0] lat_max_o,
  output logic [NUM_CH*ERR_W-1:0] err_o,
  output logic                    result_valid_o
);

  fsm_e             state_q, state_d;
  logic             freeze_s, report_s;
  logic             result_valid_q;
  logic [LAT_W-1:0] now_q;

  // Finish FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Finish FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (finish_i) state_d = REPORT;
        else          state_d = RUN;
      end
      REPORT:  state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // Finish FSM outputs broadcast to every channel
  always_comb begin
    freeze_s = 1'b1;
    report_s = 1'b0;
    case (state_q)
      RUN:     begin freeze_s = 1'b0; report_s = 1'b0; end
      REPORT:  begin freeze_s = 1'b1; report_s = 1'b1; end
      DONE:    begin freeze_s = 1'b1; report_s = 1'b0; end
      default: begin freeze_s = 1'b1; report_s = 1'b0; end
    endcase
  end

  // Timestamp base wraps silently; the report pulse is registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      now_q          <= {LAT_W{1'b0}};
      result_valid_q <= 1'b0;
    end else begin
      now_q          <= now_q + LAT_W'(1);
      result_valid_q <= report_s;
    end
  end

  assign result_valid_o = result_valid_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    blk_ctrl_chan_mon #(
      .CNT_W    (CNT_W),
      .LAT_W    (LAT_W),
      .DEPTH    (DEPTH),
      .CHAIN    (CHAIN),
      .CHECK_REF(CHECK_REF),
      .OCW      (OCW)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .freeze_i     (freeze_s),
      .report_i     (report_s),
      .start_i      (ctrl_if.ap_start[g]),
      .ready_i      (ctrl_if.ap_ready[g]),
      .done_i       (ctrl_if.ap_done[g]),
      .idle_i       (ctrl_if.ap_idle[g]),
      .continue_i   (ctrl_if.ap_continue[g]),
      .now_i        (now_q),
      .ref_cnt_i    (ref_trans_cnt_i[g*CNT_W +: CNT_W]),
      .trans_cnt_o  (trans_cnt_o[g*CNT_W +: CNT_W]),
      .done_cnt_o   (done_cnt_o[g*CNT_W +: CNT_W]),
      .outstanding_o(outstanding_o[g*OCW +: OCW]),
      .lat_last_o   (lat_last_o[g*LAT_W +: LAT_W]),
      .lat_min_o    (lat_min_o[g*LAT_W +: LAT_W]),
      .lat_max_o    (lat_max_o[g*LAT_W +: LAT_W]),
      .err_o        (err_o[g*ERR_W +: ERR_W])
    );
  end

endmodule

// File: tb/tb_blk_ctrl_multi_monitor.sv
// Self-checking bench: directed scenarios plus random handshakes compared
// every cycle against a queue-based transaction model of the monitor.
module tb_blk_ctrl_multi_monitor;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int LW  = 24;
  localparam int DEP = 8;
  localparam int OW  = 4;
  localparam int unsigned LMASK = 32'h00FF_FFFF;

  logic              clk;
  logic              rst;
  logic              finish;
  logic [NCH*CW-1:0] ref_cnt;
  logic [NCH*CW-1:0] trans_cnt, done_cnt;
  logic [NCH*OW-1:0] outstanding;
  logic [NCH*LW-1:0] lat_last, lat_min, lat_max;
  logic [NCH*4-1:0]  err;
  logic              result_valid;

  blk_ctrl_multi_monitor_if #(.NUM_CH(NCH)) bus ();

  blk_ctrl_multi_monitor #(
    .NUM_CH(NCH), .CNT_W(CW), .LAT_W(LW), .DEPTH(DEP), .CHAIN(1), .CHECK_REF(1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ctrl_if        (bus.slave),
    .finish_i       (finish),
    .ref_trans_cnt_i(ref_cnt),
    .trans_cnt_o    (trans_cnt),
    .done_cnt_o     (done_cnt),
    .outstanding_o  (outstanding),
    .lat_last_o     (lat_last),
    .lat_min_o      (lat_min),
    .lat_max_o      (lat_max),
    .err_o          (err),
    .result_valid_o (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel timestamp queues and plain counters
  int unsigned m_trans [NCH];
  int unsigned m_done  [NCH];
  int unsigned m_last  [NCH];
  int unsigned m_min   [NCH];
  int unsigned m_max   [NCH];
  bit [3:0]    m_err   [NCH];
  int unsigned m_q     [NCH][$];
  int unsigned m_now;
  int          m_state;   // 0 running, 1 reporting, 2 finished
  bit          m_rv;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_trans[c] = 0; m_done[c] = 0; m_last[c] = 0;
      m_min[c] = LMASK; m_max[c] = 0; m_err[c] = 4'b0000;
      m_q[c].delete();
    end
    m_now = 0; m_state = 0; m_rv = 1'b0;
  endfunction

  function automatic void m_stats(input int c, input int unsigned lat);
    m_last[c] = lat;
    if (lat < m_min[c]) m_min[c] = lat;
    if (lat > m_max[c]) m_max[c] = lat;
  endfunction

  function automatic void m_edge();
    if (rst) begin
      m_reset();
      return;
    end
    m_rv = (m_state == 1);
    if (m_state == 0) begin
      for (int c = 0; c < NCH; c++) begin
        bit a;
        bit d;
        int n;
        a = bus.ap_start[c] & bus.ap_ready[c];
        d = bus.ap_done[c] & bus.ap_continue[c];
        n = m_q[c].size();
        if (bus.ap_idle[c] && n > 0 && !d) m_err[c][2] = 1'b1;
        if (a) m_trans[c] = sat_inc(m_trans[c]);
        if (d) m_done[c] = sat_inc(m_done[c]);
        if (a && d && n == 0) begin
          m_stats(c, 0);
        end else begin
          if (d) begin
            if (n == 0) m_err[c][0] = 1'b1;
            else        m_stats(c, (m_now - m_q[c].pop_front()) & LMASK);
          end
          if (a) begin
            if (m_q[c].size() < DEP) m_q[c].push_back(m_now);
            else                     m_err[c][1] = 1'b1;
          end
        end
      end
      if (finish) m_state = 1;
    end else if (m_state == 1) begin
      for (int c = 0; c < NCH; c++)
        if (m_trans[c] != ref_cnt[c*CW +: CW]) m_err[c][3] = 1'b1;
      m_state = 2;
    end
    m_now = (m_now + 1) & LMASK;
  endfunction

  task automatic compare_all();
    for (int c = 0; c < NCH; c++) begin
      check_val($sformatf("trans_cnt[%0d]", c),   64'(trans_cnt[c*CW +: CW]),  64'(m_trans[c]));
      check_val($sformatf("done_cnt[%0d]", c),    64'(done_cnt[c*CW +: CW]),   64'(m_done[c]));
      check_val($sformatf("outstanding[%0d]", c), 64'(outstanding[c*OW +: OW]), 64'(m_q[c].size()));
      check_val($sformatf("lat_last[%0d]", c),    64'(lat_last[c*LW +: LW]),   64'(m_last[c]));
      check_val($sformatf("lat_min[%0d]", c),     64'(lat_min[c*LW +: LW]),    64'(m_min[c]));
      check_val($sformatf("lat_max[%0d]", c),     64'(lat_max[c*LW +: LW]),    64'(m_max[c]));
      check_val($sformatf("err[%0d]", c),         64'(err[c*4 +: 4]),          64'(m_err[c]));
    end
    check_val("result_valid", 64'(result_valid), 64'(m_rv));
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] rd, input logic [3:0] dn,
                       input logic [3:0] ct, input logic [3:0] id);
    bus.ap_start = st; bus.ap_ready = rd; bus.ap_done = dn;
    bus.ap_continue = ct; bus.ap_idle = id;
  endtask

  task automatic rand_inputs();
    for (int c = 0; c < NCH; c++) begin
      bus.ap_start[c]    = ($urandom_range(0, 99) < 35);
      bus.ap_ready[c]    = ($urandom_range(0, 99) < 70);
      bus.ap_done[c]     = ($urandom_range(0, 99) < 30);
      bus.ap_continue[c] = ($urandom_range(0, 99) < 70);
      bus.ap_idle[c]     = ($urandom_range(0, 99) < 10);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; finish = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    ref_cnt = '0;
    finish  = 1'b0;
    m_reset();
    do_reset();
    check_val("reset_lat_min0", 64'(lat_min[0 +: LW]), 64'h00FF_FFFF);

    // Ch0: start at cycle 10, completion at cycle 25
    for (int i = 0; i < 40 && m_now != 10; i++) step();
    drive(4'h1, 4'h1, 4'h0, 4'h0, 4'h0); step();
    drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 40 && m_now != 25; i++) step();
    drive(4'h0, 4'h0, 4'h1, 4'h1, 4'h0); step();
    check_val("ch0_lat_last", 64'(lat_last[0 +: LW]), 64'd15);
    check_val("ch0_lat_min",  64'(lat_min[0 +: LW]),  64'd15);
    check_val("ch0_lat_max",  64'(lat_max[0 +: LW]),  64'd15);
    check_val("ch0_trans",    64'(trans_cnt[0 +: CW]), 64'd1);

    // Ch1: completion only counts with ap_continue
    for (int i = 0; i < 3; i++) begin drive(4'h2, 4'h2, 4'h0, 4'h0, 4'h0); step(); end
    check_val("ch1_outstanding", 64'(outstanding[OW +: OW]), 64'd3);
    for (int i = 0; i < 2; i++) begin drive(4'h0, 4'h0, 4'h2, 4'h0, 4'h0); step(); end
    check_val("ch1_done_wo_cont", 64'(done_cnt[CW +: CW]), 64'd0);
    drive(4'h0, 4'h0, 4'h2, 4'h2, 4'h0); step();
    check_val("ch1_done_cont", 64'(done_cnt[CW +: CW]), 64'd1);
    check_val("ch1_outst_after", 64'(outstanding[OW +: OW]), 64'd2);

    // Ch2: nine starts into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin drive(4'h4, 4'h4, 4'h0, 4'h0, 4'h0); step(); end
    check_val("ch2_outstanding", 64'(outstanding[2*OW +: OW]), 64'd8);
    check_val("ch2_trans", 64'(trans_cnt[2*CW +: CW]), 64'd9);
    check_val("ch2_overflow", 64'(err[2*4+1]), 64'd1);

    // Ch3: orphan completion, then start+done on an empty channel
    drive(4'h0, 4'h0, 4'h8, 4'h8, 4'h0); step();
    check_val("ch3_orphan", 64'(err[3*4+0]), 64'd1);
    drive(4'h8, 4'h8, 4'h8, 4'h8, 4'h0); step();
    check_val("ch3_lat_zero", 64'(lat_last[3*LW +: LW]), 64'd0);
    check_val("ch3_outst_zero", 64'(outstanding[3*OW +: OW]), 64'd0);

    // Reset with two transactions in flight
    drive(4'h1, 4'h1, 4'h0, 4'h0, 4'h0); step(); step();
    check_val("ch0_outst_2", 64'(outstanding[0 +: OW]), 64'd2);
    rst = 1'b1; drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0); step(); rst = 1'b0;
    check_val("rst_outst", 64'(outstanding[0 +: OW]), 64'd0);
    check_val("rst_trans", 64'(trans_cnt[0 +: CW]), 64'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin rand_inputs(); step(); end

    // Reference check: ch0 sees four starts, the others five
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive((i < 4) ? 4'hF : 4'hE, 4'hF, 4'h0, 4'h0, 4'h0); step();
    end
    drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    ref_cnt = {4{32'd5}};
    finish = 1'b1; step();
    check_val("rv_not_yet", 64'(result_valid), 64'd0);
    step();
    check_val("rv_pulse", 64'(result_valid), 64'd1);
    check_val("mismatch_bits", 64'({err[15], err[11], err[7], err[3]}), 64'b0001);
    for (int i = 0; i < 20; i++) begin rand_inputs(); step(); end
    check_val("frozen_trans0", 64'(trans_cnt[0 +: CW]), 64'd4);

    // Random run ending in a finish with near-miss references
    finish = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) begin rand_inputs(); step(); end
    for (int c = 0; c < NCH; c++) ref_cnt[c*CW +: CW] = m_trans[c] + $urandom_range(0, 1);
    finish = 1'b1;
    for (int i = 0; i < 15; i++) begin rand_inputs(); step(); end

    // Reset releases the frozen state
    finish = 1'b0;
    do_reset();
    for (int i = 0; i < 50; i++) begin rand_inputs(); step(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
